// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : counter_pkg
// Description : Shared types for the multi_counter bank: the wrap/saturate
//               mode selector, a direction encoding and a clamp helper.
// Revision    : 1.0 - initial release
// ============================================================================
package counter_pkg;

    typedef enum logic {MODE_WRAP, MODE_SAT} cnt_mode_t;

    typedef enum logic {DIR_UP, DIR_DOWN} count_dir_t;

    // Unsigned minimum, used to clamp load data into 0..limit
    function automatic logic [31:0] clamp_u32(input logic [31:0] value, input logic [31:0] bound);
        return (value > bound) ? bound : value;
    endfunction

endpackage
`default_nettype wire

// File: rtl/counter_channel.sv
`default_nettype none
// ============================================================================
// Module      : counter_channel
// Description : One counter channel. Handles the clear > load > enable > hold
//               priority, wrap/saturate boundary behaviour, the registered
//               boundary tick and the combinational at_limit flag.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_channel
    import counter_pkg::*;
#(
    parameter int        W    = 8,
    parameter cnt_mode_t MODE = MODE_WRAP
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         i_clear,
    input  logic         i_load,
    input  logic [W-1:0] i_load_value,
    input  logic         i_enable,
    input  logic         i_down,
    input  logic [W-1:0] i_limit,
    output logic [W-1:0] o_count,
    output logic         o_at_limit,
    output logic         o_tick
);

    localparam logic [W-1:0] c_one  = W'(1);
    localparam logic [W-1:0] c_zero = '0;

    logic [W-1:0] r_count;
    logic         r_tick;
    logic [W-1:0] w_count_next;
    logic         w_tick_next;
    logic [W-1:0] w_load_clamped;
    logic [W-1:0] w_inc;
    logic [W-1:0] w_dec;

    // Clamped load data and the +/-1 neighbours of the current count
    always_comb begin
        w_load_clamped = (i_load_value > i_limit) ? i_limit : i_load_value;
        w_inc          = r_count + c_one;
        w_dec          = r_count - c_one;
    end

    // Next count/tick selection; limit is compared before any increment so
    // the W-bit increment can never overflow
    always_comb begin
        w_count_next = r_count;
        w_tick_next  = 1'b0;
        if (i_clear) begin
            w_count_next = c_zero;
        end else if (i_load) begin
            w_count_next = w_load_clamped;
        end else if (i_enable) begin
            if (!i_down) begin
                if (r_count < i_limit) begin
                    w_count_next = w_inc;
                    // Saturating channels flag the step that lands on limit
                    w_tick_next  = (MODE == MODE_SAT) && (w_inc == i_limit);
                end else if (MODE == MODE_WRAP) begin
                    w_count_next = c_zero;
                    w_tick_next  = 1'b1;
                end else begin
                    w_count_next = i_limit;
                    // Pinned at limit: no tick; pulled down from above: tick
                    w_tick_next  = (r_count != i_limit);
                end
            end else begin
                if (r_count > i_limit) begin
                    // Out-of-range after limit was lowered
                    w_count_next = (MODE == MODE_WRAP) ? c_zero : i_limit;
                    w_tick_next  = 1'b1;
                end else if (r_count != c_zero) begin
                    w_count_next = w_dec;
                    w_tick_next  = (MODE == MODE_SAT) && (r_count == c_one);
                end else if (MODE == MODE_WRAP) begin
                    w_count_next = i_limit;
                    w_tick_next  = 1'b1;
                end
            end
        end
    end

    // Count and tick registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_count <= c_zero;
            r_tick  <= 1'b0;
        end else begin
            r_count <= w_count_next;
            r_tick  <= w_tick_next;
        end
    end

    assign o_count    = r_count;
    assign o_tick     = r_tick;
    assign o_at_limit = i_down ? (r_count == c_zero) : (r_count >= i_limit);

endmodule
`default_nettype wire

// File: rtl/multi_counter.sv
`default_nettype none
// ============================================================================
// Module      : multi_counter
// Description : Bank of CH independent W-bit counters sharing a runtime limit
//               and a build-time wrap/saturate mode.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_counter
    import counter_pkg::*;
#(
    parameter int        CH   = 4,
    parameter int        W    = 8,
    parameter cnt_mode_t MODE = MODE_WRAP
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [CH-1:0]   clear,
    input  logic [CH-1:0]   load,
    input  logic [CH*W-1:0] load_value,
    input  logic [CH-1:0]   enable,
    input  logic [CH-1:0]   down,
    input  logic [W-1:0]    limit,
    output logic [CH*W-1:0] count,
    output logic [CH-1:0]   at_limit,
    output logic [CH-1:0]   tick
);

    // One channel per bit of the control vectors; buses are sliced i*W +: W
    generate
        for (genvar i = 0; i < CH; i++) begin : g_ch
            counter_channel #(
                .W    (W),
                .MODE (MODE)
            ) u_channel (
                .clk          (clk),
                .resetn       (resetn),
                .i_clear      (clear[i]),
                .i_load       (load[i]),
                .i_load_value (load_value[i*W +: W]),
                .i_enable     (enable[i]),
                .i_down       (down[i]),
                .i_limit      (limit),
                .o_count      (count[i*W +: W]),
                .o_at_limit   (at_limit[i]),
                .o_tick       (tick[i])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_multi_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_counter
// Description : Directed bench for multi_counter. A wrap-mode and a
//               saturate-mode instance share the same stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_counter;
    import counter_pkg::*;

    localparam int CH = 4;
    localparam int W  = 8;

    logic            clk;
    logic            resetn;
    logic [CH-1:0]   clear;
    logic [CH-1:0]   load;
    logic [CH*W-1:0] load_value;
    logic [CH-1:0]   enable;
    logic [CH-1:0]   down;
    logic [W-1:0]    limit;
    logic [CH*W-1:0] count_w, count_s;
    logic [CH-1:0]   at_w, at_s, tick_w, tick_s;

    int checks = 0;
    int errors = 0;

    multi_counter #(.CH(CH), .W(W), .MODE(MODE_WRAP)) u_wrap (
        .clk(clk), .resetn(resetn), .clear(clear), .load(load),
        .load_value(load_value), .enable(enable), .down(down), .limit(limit),
        .count(count_w), .at_limit(at_w), .tick(tick_w)
    );

    multi_counter #(.CH(CH), .W(W), .MODE(MODE_SAT)) u_sat (
        .clk(clk), .resetn(resetn), .clear(clear), .load(load),
        .load_value(load_value), .enable(enable), .down(down), .limit(limit),
        .count(count_s), .at_limit(at_s), .tick(tick_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] chv(input logic [CH*W-1:0] bus, input int c);
        return bus[c*W +: W];
    endfunction

    initial begin
        int ew;
        int es;

        resetn     = 1'b0;
        clear      = '0;
        load       = '0;
        load_value = '0;
        enable     = '0;
        down       = '0;
        limit      = 8'd9;

        // Reset state
        cyc();
        cyc();
        chk("rst_count_w", count_w, 0);
        chk("rst_count_s", count_s, 0);
        chk("rst_tick_w", {28'd0, tick_w}, 0);
        chk("rst_tick_s", {28'd0, tick_s}, 0);
        resetn = 1'b1;

        // Wrap up with limit 9: 1..9,0,1,2 (wrap) / 1..9,9,9,9 (sat)
        enable[0] = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            cyc();
            ew = i % 10;
            es = (i < 9) ? i : 9;
            chk("up_cnt_w", {24'd0, chv(count_w, 0)}, ew);
            chk("up_tick_w", {31'd0, tick_w[0]}, (ew == 0) ? 1 : 0);
            chk("up_at_w", {31'd0, at_w[0]}, (ew == 9) ? 1 : 0);
            chk("up_cnt_s", {24'd0, chv(count_s, 0)}, es);
            chk("up_tick_s", {31'd0, tick_s[0]}, (i == 9) ? 1 : 0);
            chk("up_at_s", {31'd0, at_s[0]}, (es == 9) ? 1 : 0);
        end

        // Bring ch0 to 5 then assert reset between edges
        enable[0] = 1'b0;
        clear[0]  = 1'b1;
        cyc();
        clear[0]  = 1'b0;
        enable[0] = 1'b1;
        repeat (5) cyc();
        chk("pre_rst_w", {24'd0, chv(count_w, 0)}, 5);
        chk("pre_rst_s", {24'd0, chv(count_s, 0)}, 5);
        #3;
        resetn = 1'b0;
        #1;
        chk("async_rst_cnt_w", {24'd0, chv(count_w, 0)}, 0);
        chk("async_rst_cnt_s", {24'd0, chv(count_s, 0)}, 0);
        chk("async_rst_tick_w", {31'd0, tick_w[0]}, 0);
        cyc();
        chk("rst_hold_w", {24'd0, chv(count_w, 0)}, 0);
        chk("rst_hold_s", {24'd0, chv(count_s, 0)}, 0);
        resetn = 1'b1;

        // Priority with limit 100
        limit           = 8'd100;
        load[0]         = 1'b1;
        load_value[7:0] = 8'd42;
        cyc();
        chk("load42_w", {24'd0, chv(count_w, 0)}, 42);
        chk("load42_s", {24'd0, chv(count_s, 0)}, 42);
        clear[0] = 1'b1;
        cyc();
        chk("clr_prio_w", {24'd0, chv(count_w, 0)}, 0);
        chk("clr_prio_s", {24'd0, chv(count_s, 0)}, 0);
        clear[0]        = 1'b0;
        load_value[7:0] = 8'd200;
        cyc();
        chk("load_clamp_w", {24'd0, chv(count_w, 0)}, 100);
        chk("load_clamp_s", {24'd0, chv(count_s, 0)}, 100);

        // Limit lowered below the current count
        load_value[7:0] = 8'd50;
        cyc();
        chk("load50_w", {24'd0, chv(count_w, 0)}, 50);
        load[0] = 1'b0;
        limit   = 8'd20;
        cyc();
        chk("lower_cnt_w", {24'd0, chv(count_w, 0)}, 0);
        chk("lower_tick_w", {31'd0, tick_w[0]}, 1);
        chk("lower_cnt_s", {24'd0, chv(count_s, 0)}, 20);
        chk("lower_tick_s", {31'd0, tick_s[0]}, 1);
        cyc();
        chk("after_cnt_w", {24'd0, chv(count_w, 0)}, 1);
        chk("after_tick_w", {31'd0, tick_w[0]}, 0);
        chk("pinned_cnt_s", {24'd0, chv(count_s, 0)}, 20);
        chk("pinned_tick_s", {31'd0, tick_s[0]}, 0);

        // Count down from 3 (limit 20)
        enable[0]       = 1'b0;
        load[0]         = 1'b1;
        load_value[7:0] = 8'd3;
        cyc();
        load[0]   = 1'b0;
        enable[0] = 1'b1;
        down[0]   = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            cyc();
            es = (i < 3) ? (3 - i) : 0;
            ew = (i <= 3) ? (3 - i) : (i == 4 ? 20 : 19);
            chk("dn_cnt_s", {24'd0, chv(count_s, 0)}, es);
            chk("dn_tick_s", {31'd0, tick_s[0]}, (i == 3) ? 1 : 0);
            chk("dn_at_s", {31'd0, at_s[0]}, (es == 0) ? 1 : 0);
            chk("dn_cnt_w", {24'd0, chv(count_w, 0)}, ew);
            chk("dn_tick_w", {31'd0, tick_w[0]}, (i == 4) ? 1 : 0);
        end
        enable[0] = 1'b0;
        down[0]   = 1'b0;

        // Independence with limit 7
        limit        = 8'd7;
        clear        = 4'b0010;
        load         = 4'b1100;
        load_value   = {8'd5, 8'd3, 8'd0, 8'd0};
        cyc();
        chk("ind_setup_ch3", {24'd0, chv(count_w, 3)}, 5);
        load     = '0;
        clear    = 4'b1000;
        enable   = 4'b0010;
        down     = 4'b0010;
        cyc();
        chk("ind_ch1_cnt_w", {24'd0, chv(count_w, 1)}, 7);
        chk("ind_ch1_tick_w", {31'd0, tick_w[1]}, 1);
        chk("ind_ch1_cnt_s", {24'd0, chv(count_s, 1)}, 0);
        chk("ind_ch1_tick_s", {31'd0, tick_s[1]}, 0);
        chk("ind_ch2_hold_w", {24'd0, chv(count_w, 2)}, 3);
        chk("ind_ch2_hold_s", {24'd0, chv(count_s, 2)}, 3);
        chk("ind_ch3_clr_w", {24'd0, chv(count_w, 3)}, 0);
        chk("ind_ch1_at_w", {31'd0, at_w[1]}, 0);
        chk("ind_ch1_at_s", {31'd0, at_s[1]}, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
